// File: rtl/alien_bomb.sv
// Alien bomb: picks a live formation column from an LFSR, drops one row per step,
// and reports a one-cycle player_hit when it lands on the ship.
module alien_bomb #(
    parameter int unsigned STEP_CYCLES  = 1800000,
    parameter int unsigned RELOAD_STEPS = 8,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter logic [3:0]  SHIP_Y       = 4'd13,
    parameter logic [3:0]  FLOOR_Y      = 4'd14
) (
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] alien_x,
    input  logic [3:0] alien_y,
    input  logic [7:0] alive_cols,
    input  logic [4:0] ship_x,
    input  logic       shield_hit,
    output logic       bomb_flying,
    output logic [4:0] bomb_x,
    output logic [3:0] bomb_y,
    output logic       player_hit
);

    localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned CW = $clog2(RELOAD_STEPS + 1);

    localparam logic [1:0] StCooldown = 2'd0;
    localparam logic [1:0] StAim      = 2'd1;
    localparam logic [1:0] StFall     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          flying_q, flying_d;
    logic [4:0]    x_q, x_d;
    logic [3:0]    y_q, y_d;
    logic          hit_q, hit_d;

    logic       step;
    logic [2:0] col;
    logic       terminate;

    assign step = enable && (presc_q == PW'(STEP_CYCLES - 1));
    assign col  = lfsr_q[2:0];

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cool_d    = cool_q;
        flying_d  = flying_q;
        x_d       = x_q;
        y_d       = y_q;
        hit_d     = 1'b0;
        terminate = 1'b0;
        // The LFSR free-runs so column choice keeps changing even while frozen.
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (enable) begin
            presc_d = step ? '0 : presc_q + 1'b1;
            case (state_q)
                StCooldown: begin
                    if (step) begin
                        cool_d = cool_q - 1'b1;
                        if (cool_q == CW'(1)) begin
                            state_d = StAim;
                        end
                    end
                end
                StAim: begin
                    if (alive_cols != 8'd0 && alien_y < FLOOR_Y && alive_cols[col]) begin
                        x_d      = alien_x + {1'b0, col, 1'b0};
                        y_d      = alien_y + 4'd1;
                        flying_d = 1'b1;
                        state_d  = StFall;
                    end
                end
                StFall: begin
                    if (shield_hit) begin
                        terminate = 1'b1;
                    end else if (y_q == SHIP_Y && x_q == ship_x) begin
                        terminate = 1'b1;
                        hit_d     = 1'b1;
                    end else if (step) begin
                        if (y_q == FLOOR_Y) begin
                            terminate = 1'b1;
                        end else begin
                            y_d = y_q + 4'd1;
                        end
                    end
                end
                default: state_d = StCooldown;
            endcase

            if (terminate) begin
                flying_d = 1'b0;
                x_d      = 5'd0;
                y_d      = 4'd15;
                cool_d   = CW'(RELOAD_STEPS);
                state_d  = StCooldown;
            end
        end
    end

    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            state_q  <= StCooldown;
            presc_q  <= '0;
            cool_q   <= CW'(RELOAD_STEPS);
            lfsr_q   <= LFSR_SEED;
            flying_q <= 1'b0;
            x_q      <= 5'd0;
            y_q      <= 4'd15;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cool_q   <= cool_d;
            lfsr_q   <= lfsr_d;
            flying_q <= flying_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hit_q    <= hit_d;
        end
    end

    assign bomb_flying = flying_q;
    assign bomb_x      = x_q;
    assign bomb_y      = y_q;
    assign player_hit  = hit_q;

endmodule

// File: tb/tb_alien_bomb.sv
// Scoreboard bench for alien_bomb: scenarios queue expected launch/terminate events,
// a monitor pops and compares them whenever bomb_flying changes.
module tb_alien_bomb;

    localparam int unsigned STEP   = 4;
    localparam int unsigned RELOAD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] alien_x = '0;
    logic [3:0] alien_y = '0;
    logic [7:0] alive_cols = '0;
    logic [4:0] ship_x = '0;
    logic       shield_hit = 1'b0;
    logic       bomb_flying;
    logic [4:0] bomb_x;
    logic [3:0] bomb_y;
    logic       player_hit;

    alien_bomb #(
        .STEP_CYCLES (STEP),
        .RELOAD_STEPS(RELOAD),
        .LFSR_SEED   (8'hA5),
        .SHIP_Y      (4'd13),
        .FLOOR_Y     (4'd14)
    ) dut (
        .clk_36MHz  (clk),
        .reset      (rst),
        .enable     (enable),
        .alien_x    (alien_x),
        .alien_y    (alien_y),
        .alive_cols (alive_cols),
        .ship_x     (ship_x),
        .shield_hit (shield_hit),
        .bomb_flying(bomb_flying),
        .bomb_x     (bomb_x),
        .bomb_y     (bomb_y),
        .player_hit (player_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         launch;
        int         cyc;
        logic [4:0] x;
        logic [3:0] y;
        bit         hit;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  prev_fly = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // LFSR value after n clocks since reset release.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    // First edge >= from_edge at which AIM sees a live column (it samples the prior LFSR value).
    function automatic int first_launch(input int from_edge, input logic [7:0] alive);
        logic [7:0] v;
        for (int n = from_edge; n < from_edge + 2000; n++) begin
            v = lfsr_at(n - 1);
            if (alive[v[2:0]]) return n;
        end
        return -1;
    endfunction

    task automatic push_launch(input int c, input logic [4:0] x, input logic [3:0] y);
        ev_t e;
        e.launch = 1'b1; e.cyc = c; e.x = x; e.y = y; e.hit = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_end(input int c, input bit hit);
        ev_t e;
        e.launch = 1'b0; e.cyc = c; e.x = 5'd0; e.y = 4'd15; e.hit = hit;
        q.push_back(e);
    endtask

    // Monitor: cycle counter is the number of clock edges since reset release.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            prev_fly = 1'b0;
        end else begin
            cyc = cyc + 1;
            #1;
            if (bomb_flying !== prev_fly) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", int'(bomb_flying) + 10, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("event_kind", int'(bomb_flying), int'(mon_e.launch));
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("event_x", int'(bomb_x), int'(mon_e.x));
                    chk("event_y", int'(bomb_y), int'(mon_e.y));
                    if (!mon_e.launch) chk("hit_at_end", int'(player_hit), int'(mon_e.hit));
                end
            end else if (player_hit) begin
                chk("stray_player_hit", 1, 0);
            end
            prev_fly = bomb_flying;
        end
    end

    task automatic do_reset(input logic [7:0] al, input logic [4:0] ax, input logic [3:0] ay,
                            input logic [4:0] sx);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        alive_cols = al;
        alien_x = ax;
        alien_y = ay;
        ship_x = sx;
        shield_hit = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic wait_y(input logic [3:0] target, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (bomb_y != target && n < budget);
        chk("reach_row", int'(bomb_y), int'(target));
    endtask

    int l, s1, e, p, t;

    initial begin
        // Reset values
        #12;
        chk("rst_flying", int'(bomb_flying), 0);
        chk("rst_x", int'(bomb_x), 0);
        chk("rst_y", int'(bomb_y), 15);
        chk("rst_hit", int'(player_hit), 0);

        // Launch, fall to floor, relaunch after cooldown
        do_reset(8'h01, 5'd6, 4'd3, 5'd20);
        l = first_launch(9, 8'h01);
        push_launch(l, 5'd6, 4'd4);
        s1 = (l / 4 + 1) * 4;
        e = s1 + 40;
        push_end(e, 1'b0);
        push_launch(first_launch(e + 9, 8'h01), 5'd6, 4'd4);
        wait_drain(2000);

        // Ship hit
        do_reset(8'h01, 5'd6, 4'd3, 5'd6);
        l = first_launch(9, 8'h01);
        push_launch(l, 5'd6, 4'd4);
        s1 = (l / 4 + 1) * 4;
        push_end(s1 + 33, 1'b1);
        wait_drain(2000);

        // Shield hit at row 8
        do_reset(8'h01, 5'd6, 4'd3, 5'd20);
        push_launch(first_launch(9, 8'h01), 5'd6, 4'd4);
        wait_y(4'd8, 2000);
        push_end(cyc + 1, 1'b0);
        shield_hit = 1'b1;
        @(posedge clk);
        #2;
        shield_hit = 1'b0;
        wait_drain(50);

        // Freeze mid-flight for 20 cycles; shield pulse while frozen is ignored
        do_reset(8'h01, 5'd6, 4'd3, 5'd20);
        push_launch(first_launch(9, 8'h01), 5'd6, 4'd4);
        wait_y(4'd6, 2000);
        p = cyc;
        enable = 1'b0;
        push_end(p + 56, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        shield_hit = 1'b1;
        @(posedge clk);
        #2;
        shield_hit = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("frozen_y", int'(bomb_y), 6);
        chk("frozen_flying", int'(bomb_flying), 1);
        enable = 1'b1;
        wait_drain(200);

        // No targets, formation too low, then column 7 wrap
        do_reset(8'h00, 5'd28, 4'd3, 5'd20);
        repeat (100) @(posedge clk);
        #2;
        chk("no_target_idle", int'(bomb_flying), 0);
        alive_cols = 8'h80;
        alien_y = 4'd14;
        repeat (20) @(posedge clk);
        #2;
        chk("low_formation_idle", int'(bomb_flying), 0);
        t = cyc;
        alien_y = 4'd3;
        push_launch(first_launch(t + 1, 8'h80), 5'd10, 4'd4);
        wait_drain(2000);

        // Asynchronous reset mid-flight
        do_reset(8'h01, 5'd6, 4'd3, 5'd20);
        push_launch(first_launch(9, 8'h01), 5'd6, 4'd4);
        wait_y(4'd7, 2000);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_flying", int'(bomb_flying), 0);
        chk("async_rst_x", int'(bomb_x), 0);
        chk("async_rst_y", int'(bomb_y), 15);
        chk("async_rst_hit", int'(player_hit), 0);
        q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected to finish");
        $fatal(1);
    end

endmodule
